freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter.sv | 160 ++++++++++++++++
 tb/tb_freq_meter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated-window frequency meter with packed BCD result
//
// Counts rising edges of an asynchronous input over a fixed window of
// GATE_CYCLES clock cycles. At the end of each window the count is published
// as packed BCD together with an overflow flag, and a one-cycle valid pulse is
// raised. Windows follow each other back to back with no dead cycles.
//
// Parameters:
//   GATE_CYCLES - cin cycles per measurement window (2 .. 2^32-1)
//   DIGITS      - number of BCD digits in the result (1 .. 8)
//
// Ports:
//   cin    in   1         system clock, all state on its rising edge
//   rst    in   1         asynchronous active-high reset
//   sig_in in   1         measured signal, asynchronous to cin, below cin/4
//   bcd    out  4*DIGITS  last completed count, digit 0 in bits [3:0]
//   ovf    out  1         last completed window exceeded 10^DIGITS-1 edges
//   valid  out  1         one-cycle pulse when bcd/ovf update
//   busy   out  1         high while a window is in progress
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 100000000,
    parameter int          DIGITS      = 4
) (
    input  logic                cin,
    input  logic                rst,
    input  logic                sig_in,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf,
    output logic                valid,
    output logic                busy
);

    localparam int unsigned     GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);

    localparam logic [0:0]      ST_IDLE    = 1'b0;
    localparam logic [0:0]      ST_MEASURE = 1'b1;

    // Synchroniser and edge detector
    logic                r_sync1;
    logic                r_sync2;
    logic                r_sync3;
    logic                w_rise;

    // Control
    logic [0:0]          r_state;
    logic [GW-1:0]       r_gate;
    logic                w_measuring;
    logic                w_gate_end;
    logic                w_count;

    // Edge counter
    logic [4*DIGITS-1:0] r_cnt;
    logic                r_ovf_flag;
    logic [4*DIGITS-1:0] w_cnt_next;
    logic                w_top_carry;
    logic [4*DIGITS-1:0] w_cnt_sat;
    logic                w_ovf_next;

    // Published result
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_ovf;
    logic                r_valid;

    // sig_in is asynchronous: two flops resolve metastability, the third
    // holds the previous clean sample so a rise is seen exactly once.
    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_sync3;

    // One IDLE cycle after reset, then measurement runs forever.
    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= ST_MEASURE;
        end
    end

    assign w_measuring = (r_state == ST_MEASURE);
    assign w_gate_end  = w_measuring && (r_gate == GATE_LAST);
    assign w_count     = w_measuring && w_rise;

    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            r_gate <= '0;
        end else if (w_measuring) begin
            r_gate <= w_gate_end ? '0 : (r_gate + GW'(1));
        end
    end

    // Ripple the increment through the digits combinationally so a carry
    // lands in the next digit in the same cycle as the edge that caused it.
    always_comb begin
        logic w_carry;
        w_carry    = w_count;
        w_cnt_next = r_cnt;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (r_cnt[4*i +: 4] == 4'd9) begin
                    w_cnt_next[4*i +: 4] = 4'd0;
                end else begin
                    w_cnt_next[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
                    w_carry              = 1'b0;
                end
            end
        end
        w_top_carry = w_carry;
    end

    // A carry out of the top digit pins the count at all 9s; further edges
    // keep producing a carry out and so keep it pinned.
    assign w_cnt_sat  = w_top_carry ? {DIGITS{4'd9}} : w_cnt_next;
    assign w_ovf_next = r_ovf_flag | w_top_carry;

    // At window end the closing count (including any edge in that same
    // cycle) is handed to the output register, and the counter restarts.
    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_ovf_flag <= 1'b0;
        end else if (w_gate_end) begin
            r_cnt      <= '0;
            r_ovf_flag <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_sat;
            r_ovf_flag <= w_ovf_next;
        end
    end

    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_gate_end;
            if (w_gate_end) begin
                r_bcd <= w_cnt_sat;
                r_ovf <= w_ovf_next;
            end
        end
    end

    assign bcd   = r_bcd;
    assign ovf   = r_ovf;
    assign valid = r_valid;
    assign busy  = w_measuring;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter
module tb_freq_meter;

    logic       cin    = 1'b0;
    logic       rst    = 1'b1;
    logic       sig_in = 1'b0;

    logic [7:0] bcd;
    logic       ovf;
    logic       valid;
    logic       busy;
    logic [3:0] bcd1;
    logic       ovf1;
    logic       valid1;
    logic       busy1;

    int cyc      = 0;
    int rel      = 0;
    int ph       = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int hold_err = 0;

    int         q_cyc[$];
    logic [7:0] q_bcd[$];
    logic       q_ovf[$];
    logic [3:0] q1_bcd[$];
    logic       q1_ovf[$];

    logic [7:0] last_bcd = 8'h00;
    logic       last_ovf = 1'b0;

    freq_meter #(.GATE_CYCLES(100), .DIGITS(2)) dut (
        .cin    (cin),
        .rst    (rst),
        .sig_in (sig_in),
        .bcd    (bcd),
        .ovf    (ovf),
        .valid  (valid),
        .busy   (busy)
    );

    freq_meter #(.GATE_CYCLES(100), .DIGITS(1)) dut1 (
        .cin    (cin),
        .rst    (rst),
        .sig_in (sig_in),
        .bcd    (bcd1),
        .ovf    (ovf1),
        .valid  (valid1),
        .busy   (busy1)
    );

    always #5 cin = ~cin;

    always @(posedge cin) cyc <= cyc + 1;

    always @(negedge cin) begin
        if (valid) begin
            q_cyc.push_back(cyc);
            q_bcd.push_back(bcd);
            q_ovf.push_back(ovf);
        end
        if (valid1) begin
            q1_bcd.push_back(bcd1);
            q1_ovf.push_back(ovf1);
        end
        if (!rst && !valid && (bcd !== last_bcd || ovf !== last_ovf)) hold_err++;
        last_bcd = bcd;
        last_ovf = ovf;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_q();
        q_cyc.delete();
        q_bcd.delete();
        q_ovf.delete();
        q1_bcd.delete();
        q1_ovf.delete();
    endtask

    // Drives one sig_in value per cycle, set 2 time units after each edge.
    task automatic run(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            if (period > 0) sig_in = ((ph % period) >= (period / 2));
            ph++;
            @(posedge cin);
            #2;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(posedge cin);
        #2;
        rst = 1'b0;
        rel = cyc;
        ph  = 0;
        clear_q();
    endtask

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (2) @(posedge cin);
        #2;
        chk("rst_bcd",   32'(bcd),   32'h0);
        chk("rst_ovf",   32'(ovf),   32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_bcd1",  32'(bcd1),  32'h0);

        // cin/10 square wave: 10 edges per window, pulses 100 cycles apart
        do_reset();
        chk("idle_busy", 32'(busy), 32'h0);
        run(1, 10);
        chk("measure_busy", 32'(busy), 32'h1);
        run(320, 10);
        chk("a_nvalid",    q_cyc.size(),        32'd3);
        chk("a_first_lat", q_cyc[0] - rel,      32'd101);
        chk("a_gap1",      q_cyc[1] - q_cyc[0], 32'd100);
        chk("a_gap2",      q_cyc[2] - q_cyc[1], 32'd100);
        chk("a_bcd0",      32'(q_bcd[0]),       32'h10);
        chk("a_bcd1",      32'(q_bcd[1]),       32'h10);
        chk("a_bcd2",      32'(q_bcd[2]),       32'h10);
        chk("a_ovf1",      32'(q_ovf[1]),       32'h0);
        chk("a_d1_bcd0",   32'(q1_bcd[0]),      32'h9);
        chk("a_d1_ovf0",   32'(q1_ovf[0]),      32'h1);

        // reset at gate count 50 of the fourth window
        run(30, 10);
        rst = 1'b1;
        clear_q();
        #1;
        chk("r_bcd_zero",   32'(bcd),   32'h0);
        chk("r_ovf_zero",   32'(ovf),   32'h0);
        chk("r_valid_zero", 32'(valid), 32'h0);
        chk("r_busy_zero",  32'(busy),  32'h0);
        sig_in = 1'b0;
        #1;
        run(3, 0);
        rst = 1'b0;
        rel = cyc;
        ph  = 0;
        run(160, 10);
        chk("r_nvalid",    q_cyc.size(),   32'd1);
        chk("r_first_lat", q_cyc[0] - rel, 32'd101);
        chk("r_bcd0",      32'(q_bcd[0]),  32'h10);

        // cin/8 for 12 edges: digit 0 wraps, carry reaches digit 1
        do_reset();
        run(96, 8);
        sig_in = 1'b0;
        run(114, 0);
        chk("c_nvalid",  q_cyc.size(),   32'd2);
        chk("c_bcd0",    32'(q_bcd[0]),  32'h12);
        chk("c_ovf0",    32'(q_ovf[0]),  32'h0);
        chk("c_bcd1",    32'(q_bcd[1]),  32'h00);
        chk("c_d1_bcd0", 32'(q1_bcd[0]), 32'h9);
        chk("c_d1_ovf0", 32'(q1_ovf[0]), 32'h1);
        chk("c_d1_ovf1", 32'(q1_ovf[1]), 32'h0);

        // 25 edges at cin/4 then 5 edges at cin/20
        do_reset();
        run(100, 4);
        ph = 0;
        run(110, 20);
        chk("s_d1_bcd0", 32'(q1_bcd[0]), 32'h9);
        chk("s_d1_ovf0", 32'(q1_ovf[0]), 32'h1);
        chk("s_d1_bcd1", 32'(q1_bcd[1]), 32'h5);
        chk("s_d1_ovf1", 32'(q1_ovf[1]), 32'h0);
        chk("s_bcd0",    32'(q_bcd[0]),  32'h25);
        chk("s_ovf0",    32'(q_ovf[0]),  32'h0);
        chk("s_bcd1",    32'(q_bcd[1]),  32'h05);

        // held low, then held high: one edge only
        do_reset();
        run(150, 0);
        sig_in = 1'b1;
        run(260, 0);
        chk("h_nvalid", q_cyc.size(),  32'd4);
        chk("h_bcd0",   32'(q_bcd[0]), 32'h00);
        chk("h_ovf0",   32'(q_ovf[0]), 32'h0);
        chk("h_bcd1",   32'(q_bcd[1]), 32'h01);
        chk("h_bcd2",   32'(q_bcd[2]), 32'h00);
        chk("h_bcd3",   32'(q_bcd[3]), 32'h00);

        // single rise detected in the final cycle of the second window
        do_reset();
        run(198, 0);
        sig_in = 1'b1;
        run(110, 0);
        chk("e_nvalid", q_cyc.size(),  32'd3);
        chk("e_bcd0",   32'(q_bcd[0]), 32'h00);
        chk("e_bcd1",   32'(q_bcd[1]), 32'h01);
        chk("e_bcd2",   32'(q_bcd[2]), 32'h00);

        chk("hold_stable", hold_err, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
